// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that lets several packet sources share one UART
// transmitter. A granted source keeps the transmitter for a whole packet
// (until a byte with s_last is accepted) or until it has left s_valid low
// for IDLE_TIMEOUT consecutive cycles, in which case it is dropped and
// abort pulses for one cycle.
module uart_tx_arb #(
  parameter int NUM_REQ      = 2,
  parameter int DATA_BITS    = 8,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           s_valid,
  input  logic [NUM_REQ*DATA_BITS-1:0] s_data,
  input  logic [NUM_REQ-1:0]           s_last,
  output logic [NUM_REQ-1:0]           s_ready,
  output logic                         m_valid,
  output logic [DATA_BITS-1:0]         m_data,
  input  logic                         m_ready,
  output logic [NUM_REQ-1:0]           grant,
  output logic                         abort
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(IDLE_TIMEOUT);

  typedef enum logic {ARB, OWN} state_t;

  state_t            state;
  state_t            state_next;
  logic [IDX_W-1:0]  owner;
  logic [IDX_W-1:0]  owner_inc;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  pick_idx;
  logic [IDX_W-1:0]  cand;
  logic              pick_found;
  logic [CNT_W-1:0]  idle_cnt;
  logic [CNT_W-1:0]  idle_next;
  logic              owner_valid;
  logic              xfer_last;
  logic              timeout_hit;

  assign owner_valid = s_valid[owner];
  assign owner_inc   = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
  assign idle_next   = (idle_cnt == CNT_MAX) ? idle_cnt : idle_cnt + 1'b1;
  assign xfer_last   = (state == OWN) && owner_valid && m_ready && s_last[owner];
  assign timeout_hit = (state == OWN) && !owner_valid && (idle_next == CNT_MAX);

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!pick_found && s_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
      cand = (cand == IDX_W'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ARB;
    else      state <= state_next;
  end

  // Next state: claim on any request, give back on last byte or timeout.
  always_comb begin
    state_next = state;
    case (state)
      ARB: if (pick_found) state_next = OWN;
      OWN: if (xfer_last || timeout_hit) state_next = ARB;
      default: state_next = ARB;
    endcase
  end

  // Owner, grant, round-robin pointer, idle counter and the abort pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner    <= '0;
      grant    <= '0;
      rr_ptr   <= '0;
      idle_cnt <= '0;
      abort    <= 1'b0;
    end else begin
      abort <= 1'b0;
      case (state)
        ARB: begin
          idle_cnt <= '0;
          if (pick_found) begin
            owner <= pick_idx;
            grant <= NUM_REQ'(1) << pick_idx;
          end
        end
        OWN: begin
          idle_cnt <= owner_valid ? '0 : idle_next;
          if (xfer_last || timeout_hit) begin
            grant  <= '0;
            rr_ptr <= owner_inc;
          end
          if (timeout_hit) abort <= 1'b1;
        end
        default: idle_cnt <= '0;
      endcase
    end
  end

  // Forward the owner's stream straight through; everything idle in ARB.
  always_comb begin
    m_valid = 1'b0;
    m_data  = '0;
    s_ready = '0;
    if (state == OWN) begin
      m_valid        = owner_valid;
      m_data         = s_data[owner*DATA_BITS +: DATA_BITS];
      s_ready[owner] = m_ready;
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Testbench for uart_tx_arb: directed scenarios for single packets,
// round-robin order, backpressure, idle timeout and asynchronous reset,
// followed by a randomized two-requester run checked against a
// packet-level reference model.
module tb_uart_tx_arb;

  localparam int NUM_REQ     = 2;
  localparam int DATA_BITS   = 8;
  localparam int IDLE_TMO    = 8;
  localparam int RAND_CYCLES = 600;
  localparam int MAX_LEN     = 4;

  logic                         clk = 1'b0;
  logic                         rst = 1'b0;
  logic [NUM_REQ-1:0]           s_valid;
  logic [NUM_REQ*DATA_BITS-1:0] s_data;
  logic [NUM_REQ-1:0]           s_last;
  logic [NUM_REQ-1:0]           s_ready;
  logic                         m_valid;
  logic [DATA_BITS-1:0]         m_data;
  logic                         m_ready;
  logic [NUM_REQ-1:0]           grant;
  logic                         abort;

  int checks = 0;
  int passed = 0;
  int failed = 0;

  logic [7:0] pkt [NUM_REQ][MAX_LEN];
  int         pkt_len [NUM_REQ];
  int         drv_pos [NUM_REQ];
  int         drv_gap [NUM_REQ];
  int         mdl_pos [NUM_REQ];
  logic [7:0] bp_bytes [4];

  uart_tx_arb #(
    .NUM_REQ(NUM_REQ),
    .DATA_BITS(DATA_BITS),
    .IDLE_TIMEOUT(IDLE_TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_valid(s_valid),
    .s_data(s_data),
    .s_last(s_last),
    .s_ready(s_ready),
    .m_valid(m_valid),
    .m_data(m_data),
    .m_ready(m_ready),
    .grant(grant),
    .abort(abort)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [1:0] valid, input logic [7:0] d0,
                                input logic [7:0] d1, input logic [1:0] last,
                                input logic ready);
    next_cycle();
    s_valid = valid;
    s_data  = {d1, d0};
    s_last  = last;
    m_ready = ready;
    @(negedge clk);
  endtask

  task automatic new_packet(input int i);
    pkt_len[i] = $urandom_range(1, MAX_LEN);
    for (int b = 0; b < MAX_LEN; b++) pkt[i][b] = 8'($urandom);
    drv_pos[i] = 0;
    drv_gap[i] = 0;
  endtask

  initial begin
    int   k;
    int   xfers;
    bit   busy;
    int   owner;
    int   rr;
    bit   xfer;
    int   xfer_req;
    bit   exp_mv;
    logic [31:0] exp_grant;
    logic [31:0] exp_rdy;

    bp_bytes = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    s_valid = '0;
    s_data  = '0;
    s_last  = '0;
    m_ready = 1'b0;

    // Reset values while held in reset.
    #2;
    check_output("rst_grant", grant, 0);
    check_output("rst_m_valid", m_valid, 0);
    check_output("rst_s_ready", s_ready, 0);
    check_output("rst_abort", abort, 0);
    apply_stimulus(2'b00, 8'h00, 8'h00, 2'b00, 1'b0);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check_output("rst_release_grant", grant, 0);

    // Single requester, three-byte packet, then round-robin order.
    $display("[TB] single requester packet");
    apply_stimulus(2'b01, 8'h41, 8'h00, 2'b00, 1'b1);
    check_output("t1_arb_grant", grant, 0);
    check_output("t1_arb_m_valid", m_valid, 0);
    apply_stimulus(2'b01, 8'h41, 8'h00, 2'b00, 1'b1);
    check_output("t1_grant", grant, 2'b01);
    check_output("t1_byte0", m_data, 8'h41);
    check_output("t1_s_ready", s_ready, 2'b01);
    apply_stimulus(2'b01, 8'h42, 8'h00, 2'b00, 1'b1);
    check_output("t1_byte1", m_data, 8'h42);
    apply_stimulus(2'b01, 8'h43, 8'h00, 2'b01, 1'b1);
    check_output("t1_byte2", m_data, 8'h43);
    check_output("t1_byte2_valid", m_valid, 1);
    apply_stimulus(2'b00, 8'h00, 8'h00, 2'b00, 1'b1);
    check_output("t1_release_grant", grant, 0);
    check_output("t1_release_m_valid", m_valid, 0);
    apply_stimulus(2'b11, 8'h10, 8'h20, 2'b11, 1'b1);
    check_output("rr_arb_grant", grant, 0);
    apply_stimulus(2'b11, 8'h10, 8'h20, 2'b11, 1'b1);
    check_output("rr_first_req1", grant, 2'b10);
    check_output("rr_req1_data", m_data, 8'h20);
    check_output("rr_req1_ready", s_ready, 2'b10);
    apply_stimulus(2'b01, 8'h10, 8'h00, 2'b01, 1'b1);
    check_output("rr_gap_grant", grant, 0);
    check_output("rr_gap_m_valid", m_valid, 0);
    apply_stimulus(2'b01, 8'h10, 8'h00, 2'b01, 1'b1);
    check_output("rr_then_req0", grant, 2'b01);
    check_output("rr_req0_data", m_data, 8'h10);
    apply_stimulus(2'b00, 8'h00, 8'h00, 2'b00, 1'b1);
    check_output("rr_idle_grant", grant, 0);

    // Backpressure: m_ready high one cycle in ten while req1 sends 4 bytes.
    $display("[TB] backpressure");
    k = 0;
    xfers = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      apply_stimulus((k < 4) ? 2'b10 : 2'b00, 8'h00, bp_bytes[(k < 4) ? k : 0],
                     (k == 3) ? 2'b10 : 2'b00, (cyc % 10) == 9);
      if (k < 4) begin
        if (m_valid) check_output("bp_data", m_data, bp_bytes[k]);
      end else begin
        check_output("bp_idle_m_valid", m_valid, 0);
      end
      check_output("bp_abort", abort, 0);
      if (m_valid && m_ready) begin
        k++;
        xfers++;
      end
    end
    check_output("bp_xfer_count", xfers, 4);

    // Idle timeout: req0 sends one non-last byte then goes quiet.
    $display("[TB] idle timeout");
    apply_stimulus(2'b01, 8'h55, 8'h00, 2'b00, 1'b1);
    check_output("to_arb_grant", grant, 0);
    apply_stimulus(2'b11, 8'h55, 8'h66, 2'b10, 1'b1);
    check_output("to_grant", grant, 2'b01);
    check_output("to_byte", m_data, 8'h55);
    check_output("to_nonowner_ready", s_ready, 2'b01);
    apply_stimulus(2'b10, 8'h00, 8'h66, 2'b10, 1'b1);
    check_output("to_drop_m_valid", m_valid, 0);
    check_output("to_drop_abort", abort, 0);
    for (int j = 1; j < IDLE_TMO; j++) begin
      apply_stimulus(2'b10, 8'h00, 8'h66, 2'b10, 1'b1);
      check_output("to_early_abort", abort, 0);
      check_output("to_hold_grant", grant, 2'b01);
    end
    apply_stimulus(2'b10, 8'h00, 8'h66, 2'b10, 1'b1);
    check_output("to_abort_pulse", abort, 1);
    check_output("to_abort_grant", grant, 0);
    check_output("to_abort_m_valid", m_valid, 0);
    apply_stimulus(2'b10, 8'h00, 8'h66, 2'b10, 1'b1);
    check_output("to_abort_single", abort, 0);
    check_output("to_req1_grant", grant, 2'b10);
    check_output("to_req1_data", m_data, 8'h66);
    apply_stimulus(2'b00, 8'h00, 8'h00, 2'b00, 1'b1);
    check_output("to_done_grant", grant, 0);

    // Asynchronous reset between the second and third byte of a packet.
    $display("[TB] async reset mid-packet");
    apply_stimulus(2'b01, 8'hA1, 8'h00, 2'b00, 1'b1);
    check_output("ar_arb_grant", grant, 0);
    apply_stimulus(2'b01, 8'hA1, 8'h00, 2'b00, 1'b1);
    check_output("ar_grant", grant, 2'b01);
    check_output("ar_byte0", m_data, 8'hA1);
    apply_stimulus(2'b01, 8'hA2, 8'h00, 2'b00, 1'b1);
    check_output("ar_byte1", m_data, 8'hA2);
    next_cycle();
    s_data = {8'h00, 8'hA3};
    #2;
    rst = 1'b0;
    #1;
    check_output("ar_async_m_valid", m_valid, 0);
    check_output("ar_async_s_ready", s_ready, 0);
    check_output("ar_async_grant", grant, 0);
    check_output("ar_async_abort", abort, 0);
    apply_stimulus(2'b11, 8'hB0, 8'hB1, 2'b11, 1'b1);
    check_output("ar_held_grant", grant, 0);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check_output("ar_release_grant", grant, 0);
    check_output("ar_release_m_valid", m_valid, 0);
    apply_stimulus(2'b11, 8'hB0, 8'hB1, 2'b11, 1'b1);
    check_output("ar_req0_first", grant, 2'b01);
    check_output("ar_req0_data", m_data, 8'hB0);
    check_output("ar_no_abort", abort, 0);
    apply_stimulus(2'b10, 8'h00, 8'hB1, 2'b10, 1'b1);
    check_output("ar_gap_grant", grant, 0);
    apply_stimulus(2'b10, 8'h00, 8'hB1, 2'b10, 1'b1);
    check_output("ar_req1_grant", grant, 2'b10);
    check_output("ar_req1_data", m_data, 8'hB1);
    apply_stimulus(2'b00, 8'h00, 8'h00, 2'b00, 1'b1);
    check_output("ar_done_grant", grant, 0);

    // Randomized traffic: both requesters always have a packet queued,
    // random lengths, random short mid-packet gaps and random m_ready.
    $display("[TB] randomized traffic");
    busy = 1'b0;
    owner = 0;
    rr = 0;
    xfer = 1'b0;
    xfer_req = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      new_packet(i);
      mdl_pos[i] = 0;
    end
    for (int cyc = 0; cyc < RAND_CYCLES; cyc++) begin
      next_cycle();
      if (xfer) begin
        if (drv_pos[xfer_req] == pkt_len[xfer_req] - 1) begin
          new_packet(xfer_req);
        end else begin
          drv_pos[xfer_req]++;
          if ($urandom_range(0, 3) == 0) drv_gap[xfer_req] = $urandom_range(1, 5);
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (drv_gap[i] > 0) begin
          s_valid[i] = 1'b0;
          s_last[i]  = 1'b0;
          drv_gap[i]--;
        end else begin
          s_valid[i] = 1'b1;
          s_data[i*DATA_BITS +: DATA_BITS] = pkt[i][drv_pos[i]];
          s_last[i] = (drv_pos[i] == pkt_len[i] - 1);
        end
      end
      m_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);

      exp_grant = busy ? (32'd1 << owner) : 32'd0;
      exp_mv    = busy && s_valid[owner];
      exp_rdy   = busy ? (32'(m_ready) << owner) : 32'd0;
      check_output("rnd_grant", grant, exp_grant);
      check_output("rnd_m_valid", m_valid, 32'(exp_mv));
      check_output("rnd_s_ready", s_ready, exp_rdy);
      check_output("rnd_abort", abort, 0);
      if (exp_mv) check_output("rnd_m_data", m_data, pkt[owner][mdl_pos[owner]]);

      xfer = exp_mv && m_ready;
      xfer_req = owner;
      if (!busy) begin
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
          if (s_valid[(rr + j) % NUM_REQ]) begin
            owner = (rr + j) % NUM_REQ;
            busy  = 1'b1;
          end
        end
      end else if (xfer) begin
        if (mdl_pos[owner] == pkt_len[owner] - 1) begin
          mdl_pos[owner] = 0;
          busy = 1'b0;
          rr = (owner + 1) % NUM_REQ;
        end else begin
          mdl_pos[owner]++;
        end
      end
    end

    apply_stimulus(2'b00, 8'h00, 8'h00, 2'b00, 1'b1);
    apply_stimulus(2'b00, 8'h00, 8'h00, 2'b00, 1'b1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
